// File: rtl/spi_host_master.sv
// Host-side SPI master: one 40-bit frame (address word, then data word, MSB first) per command.
// MISO is captured during the data word and returned as a one-cycle response.
module spi_host_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [19:0] CMD_ADDR,
  input  logic [19:0] CMD_DATA,
  output logic        RSP_VALID,
  output logic [19:0] RSP_DATA,
  output logic        BUSY,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_SCK_HI = 3'd2;
  localparam logic [2:0] S_SCK_LO = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  localparam logic [7:0] DIV_RELOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [5:0] LAST_BIT     = 6'd40;
  localparam logic [5:0] FIRST_RX_BIT = 6'd20;
  localparam logic       NO_GAP       = (GAP_CYCLES == 0);

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [5:0]  r_bit_cnt;
  logic [39:0] r_shift_tx;
  logic [19:0] r_rx;
  logic [19:0] r_rsp_data;
  logic        r_sck;
  logic        r_ready;
  logic        r_rsp_valid;
  logic        r_busy;

  logic w_accept;
  logic w_cnt_done;

  assign w_accept   = CMD_VALID && r_ready;
  assign w_cnt_done = (r_cnt == 8'd0);

  // The shift register empties to zero after 40 shifts, so its MSB is also the idle MOSI level.
  assign MOSI      = r_shift_tx[39];
  assign SCK       = r_sck;
  assign CMD_READY = r_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign BUSY      = r_busy;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_bit_cnt   <= 6'd0;
      r_shift_tx  <= 40'd0;
      r_rx        <= 20'd0;
      r_rsp_data  <= 20'd0;
      r_sck       <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_shift_tx <= {CMD_ADDR, CMD_DATA};
            r_bit_cnt  <= 6'd0;
            r_rx       <= 20'd0;
            r_cnt      <= DIV_RELOAD;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_cnt_done) begin
            r_cnt   <= DIV_RELOAD;
            r_sck   <= 1'b1;
            r_state <= S_SCK_HI;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        // MISO is sampled at the clock edge that raises SCK; the slave held it since its last falling edge.
        S_SCK_HI: begin
          if (w_cnt_done) begin
            r_cnt      <= DIV_RELOAD;
            r_sck      <= 1'b0;
            r_shift_tx <= {r_shift_tx[38:0], 1'b0};
            r_bit_cnt  <= r_bit_cnt + 6'd1;
            r_state    <= S_SCK_LO;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_SCK_LO: begin
          if (w_cnt_done) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_rsp_data  <= r_rx;
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_cnt   <= DIV_RELOAD;
              r_sck   <= 1'b1;
              r_state <= S_SCK_HI;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_DONE: begin
          if (NO_GAP) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= GAP_RELOAD;
            r_state <= S_GAP;
          end
        end

        S_GAP: begin
          if (w_cnt_done) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // Data-word bits land MSB first, so rising edge 20+k fills rx[19-k].
      if ((r_state == S_SETUP || r_state == S_SCK_LO) && w_cnt_done &&
          r_bit_cnt >= FIRST_RX_BIT && r_bit_cnt != LAST_BIT) begin
        r_rx <= {r_rx[18:0], MISO};
      end
    end
  end

endmodule
